memory_stage: RTL and testbench

//   Fourth pipeline stage, directly downstream of execute. Registers the E->M payload and

---
 rtl/memory_stage_pkg.sv | 46 ++++
 rtl/memory_stage_mem_load_align.sv | 38 +++
 rtl/memory_stage.sv | 147 ++++++++++++++
 tb/tb_memory_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: opcodes, funct3 access codes,
// FSM encodings, the E->M payload record and the misalignment rule.
package memory_stage_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] FUNC_LB  = 3'b000;
    localparam logic [2:0] FUNC_LH  = 3'b001;
    localparam logic [2:0] FUNC_LW  = 3'b010;
    localparam logic [2:0] FUNC_LBU = 3'b100;
    localparam logic [2:0] FUNC_LHU = 3'b101;
    localparam logic [2:0] FUNC_SB  = 3'b000;
    localparam logic [2:0] FUNC_SH  = 3'b001;
    localparam logic [2:0] FUNC_SW  = 3'b010;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_REQ  = 2'd1,
        M_WAIT = 2'd2,
        M_DONE = 2'd3
    } m_state_t;

    typedef struct packed {
        logic [31:0] val_e;
        logic [31:0] val2;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] cur_pc;
        logic [31:0] instr;
        logic [31:0] pred_pc;
        logic        commit;
    } m_payload_t;

    // Halfword accesses need bit 0 clear, word accesses need both low bits clear.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_mem_load_align.sv
// Selects the addressed byte/halfword lane of a read word and extends it
// according to the load's funct3.
module mem_load_align
    import memory_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_val
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_val = 32'd0;
        case (funct3)
            FUNC_LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
            FUNC_LH:  load_val = {{16{half_sel[15]}}, half_sel};
            FUNC_LW:  load_val = rdata;
            FUNC_LBU: load_val = {24'd0, byte_sel};
            FUNC_LHU: load_val = {16'd0, half_sel};
            default:  load_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: registers the E->M payload, runs one load/store on
// the data bus per instruction and hands the result to writeback.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            e_to_m_valid,
    output logic            m_allow_in,
    input  logic            w_allow_in,
    output logic            m_to_w_valid,
    output logic            m_valid,
    input  logic [XLEN-1:0] e_valE,
    input  logic [XLEN-1:0] E_val2,
    input  logic [6:0]      E_opcode,
    input  logic [2:0]      E_funct3,
    input  logic [4:0]      E_rd,
    input  logic [XLEN-1:0] E_pc,
    input  logic [XLEN-1:0] E_cur_pc,
    input  logic [XLEN-1:0] E_instr,
    input  logic [XLEN-1:0] E_pred_pc,
    input  logic            E_commit,
    output logic [XLEN-1:0] M_valE,
    output logic [XLEN-1:0] M_val2,
    output logic [6:0]      M_opcode,
    output logic [2:0]      M_funct3,
    output logic [4:0]      M_rd,
    output logic [XLEN-1:0] M_pc,
    output logic [XLEN-1:0] M_cur_pc,
    output logic [XLEN-1:0] M_instr,
    output logic [XLEN-1:0] M_pred_pc,
    output logic            M_commit,
    output logic [XLEN-1:0] m_valM,
    output logic            m_misalign,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    m_state_t    state_reg, state_next;
    m_payload_t  pl_reg;
    logic        m_valid_reg;
    logic        misalign_reg;
    logic [31:0] valm_reg;
    logic [31:0] load_val;

    logic e_mem_op, e_misalign, mem_op, is_store, m_ready_go, capture, leave;

    assign e_mem_op   = (E_opcode == OP_LOAD) || (E_opcode == OP_STORE);
    assign e_misalign = e_mem_op && is_misaligned(E_funct3, e_valE[1:0]);
    assign mem_op     = (pl_reg.opcode == OP_LOAD) || (pl_reg.opcode == OP_STORE);
    assign is_store   = pl_reg.opcode == OP_STORE;

    assign m_ready_go   = ~mem_op | misalign_reg | (state_reg == M_DONE);
    assign m_allow_in   = ~m_valid_reg | (m_ready_go & w_allow_in);
    assign m_to_w_valid = m_valid_reg & m_ready_go;
    assign capture      = e_to_m_valid & m_allow_in;
    assign leave        = m_to_w_valid & w_allow_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg  <= 1'b0;
            misalign_reg <= 1'b0;
            valm_reg     <= 32'd0;
            state_reg    <= M_IDLE;
        end else begin
            state_reg <= state_next;
            if (m_allow_in)
                m_valid_reg <= e_to_m_valid;
            if (capture) begin
                misalign_reg <= e_misalign;
                valm_reg     <= 32'd0;
            end else if (state_reg == M_WAIT && dmem_rvalid) begin
                valm_reg <= load_val;
            end
        end
    end

    // Payload has no reset: it is only meaningful while m_valid is set.
    always_ff @(posedge clk) begin
        if (capture)
            pl_reg <= '{val_e: e_valE, val2: E_val2, opcode: E_opcode, funct3: E_funct3,
                        rd: E_rd, pc: E_pc, cur_pc: E_cur_pc, instr: E_instr,
                        pred_pc: E_pred_pc, commit: E_commit};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            M_REQ:   if (dmem_ready)  state_next = is_store ? M_DONE : M_WAIT;
            M_WAIT:  if (dmem_rvalid) state_next = M_DONE;
            M_DONE:  if (leave)       state_next = M_IDLE;
            default: state_next = M_IDLE;
        endcase
        // Capture only happens when the previous op is leaving, so it overrides.
        if (capture)
            state_next = (e_mem_op && !e_misalign) ? M_REQ : M_IDLE;
    end

    mem_load_align u_load_align (
        .rdata    (dmem_rdata),
        .addr_lo  (pl_reg.val_e[1:0]),
        .funct3   (pl_reg.funct3),
        .load_val (load_val)
    );

    // Bus outputs derive only from held payload, so they are stable throughout REQ.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_lane
            assign dmem_wdata[8*gi +: 8] =
                (pl_reg.funct3 == FUNC_SB) ? pl_reg.val2[7:0] :
                (pl_reg.funct3 == FUNC_SH) ? pl_reg.val2[8*(gi%2) +: 8] :
                                             pl_reg.val2[8*gi +: 8];
            assign dmem_wstrb[gi] = is_store && (
                (pl_reg.funct3 == FUNC_SW) ||
                (pl_reg.funct3 == FUNC_SH && pl_reg.val_e[1] == (gi >= 2)) ||
                (pl_reg.funct3 == FUNC_SB && pl_reg.val_e[1:0] == 2'(gi)));
        end
    endgenerate

    assign dmem_req   = state_reg == M_REQ;
    assign dmem_we    = is_store;
    assign dmem_addr  = {pl_reg.val_e[31:2], 2'b00};

    assign m_valid    = m_valid_reg;
    assign m_misalign = misalign_reg;
    assign m_valM     = valm_reg;
    assign M_valE     = pl_reg.val_e;
    assign M_val2     = pl_reg.val2;
    assign M_opcode   = pl_reg.opcode;
    assign M_funct3   = pl_reg.funct3;
    assign M_rd       = pl_reg.rd;
    assign M_pc       = pl_reg.pc;
    assign M_cur_pc   = pl_reg.cur_pc;
    assign M_instr    = pl_reg.instr;
    assign M_pred_pc  = pl_reg.pred_pc;
    assign M_commit   = pl_reg.commit;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: the bench plays execute, writeback and the
// data memory, driving each handshake by hand and checking hand-computed results.
module tb_memory_stage;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        e_to_m_valid = 1'b0, w_allow_in = 1'b1;
    logic        m_allow_in, m_to_w_valid, m_valid;
    logic [31:0] e_valE = '0, E_val2 = '0, E_pc = '0, E_cur_pc = '0, E_instr = '0, E_pred_pc = '0;
    logic [6:0]  E_opcode = '0;
    logic [2:0]  E_funct3 = '0;
    logic [4:0]  E_rd = '0;
    logic        E_commit = 1'b0;
    logic [31:0] M_valE, M_val2, M_pc, M_cur_pc, M_instr, M_pred_pc, m_valM;
    logic [6:0]  M_opcode;
    logic [2:0]  M_funct3;
    logic [4:0]  M_rd;
    logic        M_commit, m_misalign;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;
    int bus_ops = 0;

    always #5 clk = ~clk;

    memory_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in),
        .w_allow_in(w_allow_in), .m_to_w_valid(m_to_w_valid), .m_valid(m_valid),
        .e_valE(e_valE), .E_val2(E_val2), .E_opcode(E_opcode), .E_funct3(E_funct3),
        .E_rd(E_rd), .E_pc(E_pc), .E_cur_pc(E_cur_pc), .E_instr(E_instr),
        .E_pred_pc(E_pred_pc), .E_commit(E_commit),
        .M_valE(M_valE), .M_val2(M_val2), .M_opcode(M_opcode), .M_funct3(M_funct3),
        .M_rd(M_rd), .M_pc(M_pc), .M_cur_pc(M_cur_pc), .M_instr(M_instr),
        .M_pred_pc(M_pred_pc), .M_commit(M_commit),
        .m_valM(m_valM), .m_misalign(m_misalign),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    // Advance one clock; inputs and outputs are both handled #1 after the edge.
    task automatic tick();
        if (dmem_req && dmem_ready) bus_ops++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; e_to_m_valid = 1'b0; w_allow_in = 1'b1;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        bus_ops = 0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] v2);
        E_opcode = op; E_funct3 = f3; e_valE = addr; E_val2 = v2;
        E_rd = addr[6:2]; E_pc = addr + 32'h1000; E_commit = 1'b1;
        e_to_m_valid = 1'b1;
        tick();
        e_to_m_valid = 1'b0;
        $display("[TB] txn op=%b f3=%0d addr=%h v2=%h", op, f3, addr, v2);
    endtask

    // Load with ready on the first REQ cycle and rvalid one cycle later.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd_word);
        issue(OPC_LOAD, f3, addr, 32'd0);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd_word;
        tick();
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_dmem_req got %b want 0", dmem_req); end
        tests_run++; if (m_misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got %b want 0", m_misalign); end
        tests_run++; if (m_valM !== 32'd0) begin tests_failed++; $display("FAIL reset_valM got %h want 0", m_valM); end
        tests_run++; if ({m_allow_in, m_to_w_valid} !== 2'b10) begin tests_failed++; $display("FAIL reset_handshake got %b want 10", {m_allow_in, m_to_w_valid}); end
        rst = 1'b0;
    endtask

    task automatic test_lw();
        do_reset();
        issue(OPC_LOAD, 3'b010, 32'h100, 32'd0);
        tests_run++; if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 32'h100}) begin tests_failed++; $display("FAIL lw_req got req=%b we=%b addr=%h want 1 0 00000100", dmem_req, dmem_we, dmem_addr); end
        tests_run++; if (m_to_w_valid !== 1'b0) begin tests_failed++; $display("FAIL lw_early1 got %b want 0", m_to_w_valid); end
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        tests_run++; if ({dmem_req, m_to_w_valid} !== 2'b00) begin tests_failed++; $display("FAIL lw_wait got req=%b mtw=%b want 0 0", dmem_req, m_to_w_valid); end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_rvalid = 1'b0;
        tests_run++; if (m_to_w_valid !== 1'b1) begin tests_failed++; $display("FAIL lw_done got %b want 1", m_to_w_valid); end
        tests_run++; if (m_valM !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_valM got %h want deadbeef", m_valM); end
        tests_run++; if ({M_valE, M_rd, M_pc} !== {32'h100, 5'd0, 32'h1100}) begin tests_failed++; $display("FAIL lw_payload got valE=%h rd=%0d pc=%h", M_valE, M_rd, M_pc); end
        tick();
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL lw_drain got %b want 0", m_valid); end
    endtask

    task automatic test_sub_word_loads();
        do_reset();
        do_load(3'b000, 32'h103, 32'h80112233);
        tests_run++; if (m_valM !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb got %h want ffffff80", m_valM); end
        tick();
        do_load(3'b100, 32'h103, 32'h80112233);
        tests_run++; if (m_valM !== 32'h00000080) begin tests_failed++; $display("FAIL lbu got %h want 00000080", m_valM); end
        tick();
        do_load(3'b001, 32'h102, 32'h80112233);
        tests_run++; if (m_valM !== 32'hFFFF8011) begin tests_failed++; $display("FAIL lh got %h want ffff8011", m_valM); end
        tick();
        do_load(3'b101, 32'h100, 32'h8011F00F);
        tests_run++; if (m_valM !== 32'h0000F00F) begin tests_failed++; $display("FAIL lhu got %h want 0000f00f", m_valM); end
        tick();
        do_load(3'b000, 32'h101, 32'h80112233);
        tests_run++; if (m_valM !== 32'h00000022) begin tests_failed++; $display("FAIL lb_lane1 got %h want 00000022", m_valM); end
        tick();
    endtask

    task automatic test_stores();
        do_reset();
        issue(OPC_STORE, 3'b001, 32'h202, 32'h1234ABCD);
        tests_run++; if ({dmem_req, dmem_we, dmem_addr} !== {2'b11, 32'h200}) begin tests_failed++; $display("FAIL sh_req got req=%b we=%b addr=%h want 1 1 00000200", dmem_req, dmem_we, dmem_addr); end
        tests_run++; if ({dmem_wstrb, dmem_wdata} !== {4'b1100, 32'hABCDABCD}) begin tests_failed++; $display("FAIL sh_data got strb=%b wdata=%h want 1100 abcdabcd", dmem_wstrb, dmem_wdata); end
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        tests_run++; if ({m_to_w_valid, dmem_req, m_valM} !== {2'b10, 32'd0}) begin tests_failed++; $display("FAIL sh_done got mtw=%b req=%b valM=%h want 1 0 0", m_to_w_valid, dmem_req, m_valM); end
        tick();
        issue(OPC_STORE, 3'b000, 32'h101, 32'h00000055);
        tests_run++; if ({dmem_wstrb, dmem_wdata} !== {4'b0010, 32'h55555555}) begin tests_failed++; $display("FAIL sb_data got strb=%b wdata=%h want 0010 55555555", dmem_wstrb, dmem_wdata); end
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        tick();
        issue(OPC_STORE, 3'b010, 32'h20C, 32'hCAFE0123);
        tests_run++; if ({dmem_wstrb, dmem_wdata, dmem_addr} !== {4'b1111, 32'hCAFE0123, 32'h20C}) begin tests_failed++; $display("FAIL sw_data got strb=%b wdata=%h addr=%h", dmem_wstrb, dmem_wdata, dmem_addr); end
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        tick();
    endtask

    task automatic test_bus_stall();
        do_reset();
        issue(OPC_LOAD, 3'b010, 32'h300, 32'd0);
        // Execute offers a different op during the stall; it must not be taken.
        E_opcode = OPC_STORE; e_valE = 32'h400; E_val2 = 32'h99; e_to_m_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if ({dmem_req, dmem_addr, m_allow_in} !== {1'b1, 32'h300, 1'b0}) begin tests_failed++; $display("FAIL stall_%0d got req=%b addr=%h allow=%b", i, dmem_req, dmem_addr, m_allow_in); end
            tick();
        end
        e_to_m_valid = 1'b0;
        tests_run++; if ({M_valE, M_opcode} !== {32'h300, OPC_LOAD}) begin tests_failed++; $display("FAIL stall_hold got valE=%h op=%b", M_valE, M_opcode); end
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BADF00D;
        tick();
        dmem_rvalid = 1'b0;
        tests_run++; if ({m_to_w_valid, m_valM, bus_ops} !== {1'b1, 32'h0BADF00D, 32'd1}) begin tests_failed++; $display("FAIL stall_done got mtw=%b valM=%h ops=%0d", m_to_w_valid, m_valM, bus_ops); end
        tick();
    endtask

    task automatic test_wb_stall();
        do_reset();
        w_allow_in = 1'b0;
        do_load(3'b010, 32'h500, 32'h11223344);
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++; if ({m_to_w_valid, m_allow_in, dmem_req, m_valM, M_valE} !== {3'b100, 32'h11223344, 32'h500}) begin tests_failed++; $display("FAIL wbstall_%0d got mtw=%b allow=%b req=%b valM=%h valE=%h", i, m_to_w_valid, m_allow_in, dmem_req, m_valM, M_valE); end
        end
        tests_run++; if (bus_ops !== 1) begin tests_failed++; $display("FAIL wbstall_ops got %0d want 1", bus_ops); end
        w_allow_in = 1'b1;
        tick();
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL wbstall_drain got %b want 0", m_valid); end
    endtask

    task automatic test_misalign();
        do_reset();
        issue(OPC_LOAD, 3'b010, 32'h102, 32'd0);
        tests_run++; if ({m_misalign, dmem_req, m_to_w_valid, m_valM} !== {3'b101, 32'd0}) begin tests_failed++; $display("FAIL misalign got mis=%b req=%b mtw=%b valM=%h", m_misalign, dmem_req, m_to_w_valid, m_valM); end
        tick();
        tests_run++; if ({m_valid, bus_ops} !== {1'b0, 32'd0}) begin tests_failed++; $display("FAIL misalign_drain got valid=%b ops=%0d", m_valid, bus_ops); end
        issue(OPC_STORE, 3'b001, 32'h201, 32'h1);
        tests_run++; if ({m_misalign, dmem_req} !== 2'b10) begin tests_failed++; $display("FAIL sh_misalign got mis=%b req=%b", m_misalign, dmem_req); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_load(3'b010, 32'h700, 32'h77777777);
        issue(OPC_STORE, 3'b010, 32'h704, 32'h44444444);
        tests_run++; if ({dmem_req, dmem_we, dmem_addr, M_valE} !== {2'b11, 32'h704, 32'h704}) begin tests_failed++; $display("FAIL b2b_req got req=%b we=%b addr=%h valE=%h", dmem_req, dmem_we, dmem_addr, M_valE); end
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        issue(OPC_ALU, 3'b000, 32'h12345678, 32'd0);
        tests_run++; if ({m_to_w_valid, dmem_req, m_valM, M_valE} !== {2'b10, 32'd0, 32'h12345678}) begin tests_failed++; $display("FAIL alu_pass got mtw=%b req=%b valM=%h valE=%h", m_to_w_valid, dmem_req, m_valM, M_valE); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        issue(OPC_LOAD, 3'b010, 32'h600, 32'd0);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if ({m_valid, dmem_req, m_to_w_valid} !== 3'b000) begin tests_failed++; $display("FAIL rstmid got valid=%b req=%b mtw=%b want 000", m_valid, dmem_req, m_to_w_valid); end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_rvalid = 1'b0;
        tests_run++; if ({m_valid, m_to_w_valid, m_valM} !== {2'b00, 32'd0}) begin tests_failed++; $display("FAIL stray_rvalid got valid=%b mtw=%b valM=%h", m_valid, m_to_w_valid, m_valM); end
    endtask

    initial begin
        #1;
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_bus_stall();
        test_wb_stall();
        test_misalign();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
